aire_sequencer: RTL and testbench
=================================

Name: aire_sequencer

Overview:
Compressor/fan sequencer that sits behind the air-conditioner control FSM. It takes the user-selected power, fan speed and the thermostat cooling demand, and drives the physical fan and compressor enables. It enforces a fan soft-start ramp, a compressor anti-short-cycle minimum off-time, and a fan purge after power-off.

Parameters:
RAMP_TICKS, 4, clock cycles between successive fan speed steps
MIN_OFF, 16, minimum cycles the compressor must stay off before it may restart
PURGE_TICKS, 8, cycles the fan stays at Low after power-off before stopping
CW, 8, width of the internal counters; must hold max(RAMP_TICKS, MIN_OFF, PURGE_TICKS)

Ports:
clock  input  1  system clock; all logic is rising-edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
on  input  1  power request from the control FSM
speed_req  input  2  target fan speed: 01 Low, 10 Mid, 11 High; 00 is treated as 01
demand  input  1  thermostat cooling call; 1 = compressor wanted
fan_speed  output  2  current fan drive: 00 off, 01 Low, 10 Mid, 11 High
comp_en  output  1  compressor enable
state  output  3  current sequencer state encoding

Behaviour:
- All outputs and counters are registered.
  - reset=0 forces state=000, fan_speed=00, comp_en=0, ramp_cnt=0, purge_cnt=0, off_cnt=0.
  - This happens asynchronously, without waiting for a clock edge.
- States: IDLE=000, FAN=001, COMP_DELAY=010, RUN=011, PURGE=100. Encodings 101–111 go to IDLE on the next edge.
- target = speed_req, with 00 mapped to 01 (further clamped under the optional feature).
- Fan ramp is active in FAN, COMP_DELAY and RUN:
  - If fan_speed != target, ramp_cnt increments each cycle.
  - When ramp_cnt == RAMP_TICKS-1, fan_speed steps one level toward target (up or down) and ramp_cnt clears.
  - ramp_cnt is held at 0 while fan_speed == target.
  - fan_speed never goes below 01 in these states.
  - A target change mid-ramp redirects the ramp without clearing ramp_cnt.
- off_cnt:
  - Increments every cycle while comp_en=0 and saturates at MIN_OFF.
  - Clears to 0 on the edge where comp_en falls.
  - Is 0 after reset, so the first compressor start waits MIN_OFF cycles.
- Transitions (evaluated at each edge; on=0 has the highest priority in every non-IDLE state):
  - IDLE: on=1 -> FAN, fan_speed=01 on the same edge.
  - FAN: on=0 -> PURGE. Else fan_speed==target and demand=1 -> COMP_DELAY. Else stay (fan-only operation).
  - COMP_DELAY: on=0 -> PURGE. Else demand=0 -> FAN. Else off_cnt==MIN_OFF -> RUN with comp_en=1 on that edge. Else stay.
  - RUN: on=0 -> PURGE with comp_en=0. Else demand=0 -> FAN with comp_en=0. Otherwise comp_en stays 1 and the ramp tracks target.
  - PURGE: comp_en=0, fan_speed forced to 01 on entry, purge_cnt increments.
    - When purge_cnt==PURGE_TICKS-1: -> IDLE, fan_speed=00, purge_cnt=0.
    - on=1 during PURGE -> FAN from 01, purge_cnt=0.
- comp_en=1 only in RUN. Leaving RUN drops comp_en on the transition edge.
- Simultaneous on=0 and demand change: on=0 wins.
- A speed change does not affect compressor state.

Optional Feature:
AIRE_ECO_EN
- Defined: target is clamped to 10, so speed_req=11 behaves as Mid and fan_speed never exceeds 10; MIN_OFF is effectively doubled, so COMP_DELAY requires off_cnt==2*MIN_OFF and off_cnt saturates there (CW must cover it).
- Undefined: full 01–11 speed range and single MIN_OFF as described above.

Test Plan:
1. Reset pulse, then on=1, speed_req=11, demand=0 -> fan_speed 01 at the first edge, 10 four cycles later, 11 four cycles after that; state=001, comp_en=0 throughout.
2. After reset deassert, on=1, speed_req=01, demand=1 -> state 001 then 010 → COMP_DELAY until off_cnt reaches 16, then state=011 and comp_en=1 on that edge.
3. In RUN, demand 1->0 -> state=001, comp_en=0; demand back to 1 next cycle -> state=010, with comp_en staying 0 for 16 cycles before RUN.
4. In RUN at fan 11, on=0 -> next edge comp_en=0, fan_speed=01, state=100; after 8 cycles state=000, fan_speed=00. A variant raising on=1 at purge cycle 3 -> state=001, ramp resumes from 01.
5. In RUN, speed_req 11->01 -> fan steps 11->10->01 at 4-cycle intervals while comp_en stays 1. With AIRE_ECO_EN, speed_req=11 yields a maximum fan_speed of 10.
6. Drive reset=0 between clock edges during RUN -> fan_speed=00, comp_en=0, state=000 immediately; after release, restart obeys the full MIN_OFF wait.

Source files
------------

// File: rtl/aire_sequencer.sv
// aire_sequencer: compressor/fan sequencer behind the air-conditioner control FSM.
// It ramps the fan gently, keeps the compressor off for a minimum time before a
// restart, and keeps the fan running at Low for a purge period after power-off.
// Optional build macro: AIRE_ECO_EN. When it is defined, the fan is capped at Mid
// and the compressor minimum off-time is doubled.
module aire_sequencer #(
  parameter int RAMP_TICKS  = 4,
  parameter int MIN_OFF     = 16,
  parameter int PURGE_TICKS = 8,
  parameter int CW          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       on,
  input  logic [1:0] speed_req,
  input  logic       demand,
  output logic [1:0] fan_speed,
  output logic       comp_en,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    FAN        = 3'b001,
    COMP_DELAY = 3'b010,
    RUN        = 3'b011,
    PURGE      = 3'b100
  } state_t;

`ifdef AIRE_ECO_EN
  localparam int OFF_LIMIT = 2 * MIN_OFF;
`else
  localparam int OFF_LIMIT = MIN_OFF;
`endif

  localparam logic [CW-1:0] OFF_MAX    = CW'(OFF_LIMIT);
  localparam logic [CW-1:0] RAMP_LAST  = CW'(RAMP_TICKS - 1);
  localparam logic [CW-1:0] PURGE_LAST = CW'(PURGE_TICKS - 1);

  state_t        state_q, state_d;
  logic [1:0]    fan_d;
  logic          comp_d;
  logic [CW-1:0] ramp_cnt, ramp_d;
  logic [CW-1:0] purge_cnt, purge_d;
  logic [CW-1:0] off_cnt, off_d;
  logic [1:0]    target;
  logic [1:0]    ramp_fan;
  logic [CW-1:0] ramp_nxt;

  assign state = state_q;

  // Effective fan target: 00 means Low; eco builds cap the fan at Mid.
  always_comb begin
    target = (speed_req == 2'b00) ? 2'b01 : speed_req;
`ifdef AIRE_ECO_EN
    if (target == 2'b11) target = 2'b10;
`endif
  end

  // Soft-start ramp: one speed step toward the target every RAMP_TICKS cycles.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    ramp_fan = fan_speed;
    ramp_nxt = '0;
    if (fan_speed != target) begin
      if (ramp_cnt == RAMP_LAST)
        ramp_fan = (target > fan_speed) ? fan_speed + 2'd1 : fan_speed - 2'd1;
      else
        ramp_nxt = ramp_cnt + CW'(1);
    end
  end

  // Next-state, next-output and counter logic for the sequencer.
  always_comb begin
    state_d = state_q;
    fan_d   = fan_speed;
    comp_d  = comp_en;
    ramp_d  = ramp_cnt;
    purge_d = purge_cnt;

    case (state_q)
      IDLE: begin
        fan_d  = 2'b00;
        comp_d = 1'b0;
        ramp_d = '0;
        if (on) begin
          state_d = FAN;
          fan_d   = 2'b01;
        end
      end

      FAN, COMP_DELAY, RUN: begin
        if (!on) begin
          // Power-off beats any demand change: drop the compressor, fan to Low.
          state_d = PURGE;
          fan_d   = 2'b01;
          comp_d  = 1'b0;
          ramp_d  = '0;
          purge_d = '0;
        end else begin
          fan_d  = ramp_fan;
          ramp_d = ramp_nxt;
          if (state_q == FAN) begin
            if (fan_speed == target && demand) state_d = COMP_DELAY;
          end else if (state_q == COMP_DELAY) begin
            if (!demand) begin
              state_d = FAN;
            end else if (off_cnt == OFF_MAX) begin
              state_d = RUN;
              comp_d  = 1'b1;
            end
          end else begin
            if (!demand) begin
              state_d = FAN;
              comp_d  = 1'b0;
            end
          end
        end
      end

      PURGE: begin
        comp_d = 1'b0;
        fan_d  = 2'b01;
        ramp_d = '0;
        if (on) begin
          state_d = FAN;
          purge_d = '0;
        end else if (purge_cnt == PURGE_LAST) begin
          state_d = IDLE;
          fan_d   = 2'b00;
          purge_d = '0;
        end else begin
          purge_d = purge_cnt + CW'(1);
        end
      end

      default: begin
        // Unused encodings recover to IDLE with everything off.
        state_d = IDLE;
        fan_d   = 2'b00;
        comp_d  = 1'b0;
        ramp_d  = '0;
        purge_d = '0;
      end
    endcase

    // Anti-short-cycle timer: restarts when the compressor drops, saturates at the limit.
    off_d = off_cnt;
    if (comp_en && !comp_d)
      off_d = '0;
    else if (!comp_en && off_cnt < OFF_MAX)
      off_d = off_cnt + CW'(1);
  end

  // State, output and counter registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      fan_speed <= 2'b00;
      comp_en   <= 1'b0;
      ramp_cnt  <= '0;
      purge_cnt <= '0;
      off_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      fan_speed <= fan_d;
      comp_en   <= comp_d;
      ramp_cnt  <= ramp_d;
      purge_cnt <= purge_d;
      off_cnt   <= off_d;
    end
  end

endmodule

// File: tb/tb_aire_sequencer.sv
// Self-checking bench for aire_sequencer: a reference model predicts the outputs
// after every clock edge, and a monitor compares them against the DUT.
module tb_aire_sequencer;

  localparam int RAMP_TICKS  = 4;
  localparam int MIN_OFF     = 16;
  localparam int PURGE_TICKS = 8;
`ifdef AIRE_ECO_EN
  localparam int OFF_NEED = 2 * MIN_OFF;
  localparam int MAX_FAN  = 2;
`else
  localparam int OFF_NEED = MIN_OFF;
  localparam int MAX_FAN  = 3;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       on = 1'b0;
  logic [1:0] speed_req = 2'b01;
  logic       demand = 1'b0;
  logic [1:0] fan_speed;
  logic       comp_en;
  logic [2:0] state;

  aire_sequencer #(
    .RAMP_TICKS (RAMP_TICKS),
    .MIN_OFF    (MIN_OFF),
    .PURGE_TICKS(PURGE_TICKS),
    .CW         (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .on       (on),
    .speed_req(speed_req),
    .demand   (demand),
    .fan_speed(fan_speed),
    .comp_en  (comp_en),
    .state    (state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] fan;
    logic       comp;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the operating mode plus the timers that gate each move.
  int m_mode;     // 0 idle, 1 fan only, 2 waiting for compressor, 3 running, 4 purging
  int m_fan;      // 0..3
  int m_comp;
  int m_step_age; // cycles spent waiting toward the next fan step
  int m_purge_age;
  int m_off_age;  // cycles the compressor has been off, capped at OFF_NEED

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fan = 0; m_comp = 0;
    m_step_age = 0; m_purge_age = 0; m_off_age = 0;
  endtask

  function automatic int goal(input int spd);
    int g;
    g = (spd == 0) ? 1 : spd;
    if (g > MAX_FAN) g = MAX_FAN;
    return g;
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input int o, input int spd, input int dem);
    int g, was_comp, fan_now;
    g        = goal(spd);
    was_comp = m_comp;
    fan_now  = m_fan;
    if (m_mode == 0) begin
      if (o != 0) begin m_mode = 1; m_fan = 1; end
    end else if (m_mode == 4) begin
      if (o != 0) begin
        m_mode = 1; m_fan = 1; m_purge_age = 0;
      end else if (m_purge_age == PURGE_TICKS - 1) begin
        m_mode = 0; m_fan = 0; m_purge_age = 0;
      end else begin
        m_purge_age++;
      end
    end else if (o == 0) begin
      m_mode = 4; m_fan = 1; m_comp = 0; m_step_age = 0; m_purge_age = 0;
    end else begin
      if (m_fan == g) begin
        m_step_age = 0;
      end else if (m_step_age == RAMP_TICKS - 1) begin
        m_fan      = (g > m_fan) ? m_fan + 1 : m_fan - 1;
        m_step_age = 0;
      end else begin
        m_step_age++;
      end
      case (m_mode)
        1: if (fan_now == g && dem != 0) m_mode = 2;
        2: if (dem == 0) m_mode = 1;
           else if (m_off_age == OFF_NEED) begin m_mode = 3; m_comp = 1; end
        default: if (dem == 0) begin m_mode = 1; m_comp = 0; end
      endcase
    end
    if (was_comp != 0 && m_comp == 0) m_off_age = 0;
    else if (was_comp == 0 && m_off_age < OFF_NEED) m_off_age++;
  endtask

  task automatic push_expect();
    exp_t e;
    e.fan  = 2'(m_fan);
    e.comp = (m_comp != 0);
    e.st   = 3'(m_mode);
    exp_q.push_back(e);
  endtask

  // One clock of synchronous stimulus with reset released.
  task automatic drive(input int o, input int spd, input int dem, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset     = 1'b1;
      on        = (o != 0);
      speed_req = 2'(spd);
      demand    = (dem != 0);
      model_step(o, spd, dem);
      push_expect();
    end
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      push_expect();
    end
  endtask

  // Assert reset midway between edges and confirm outputs clear without a clock.
  task automatic async_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async_fan", int'(fan_speed), 0);
    check("async_comp", int'(comp_en), 0);
    check("async_state", int'(state), 0);
    model_reset();
  endtask

  // Monitor: the DUT presents a new output set after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fan_speed", int'(fan_speed), int'(e.fan));
        check("comp_en", int'(comp_en), int'(e.comp));
        check("state", int'(state), int'(e.st));
      end
    end
  end

  // Stimulus: directed scenarios first, then a long randomized run.
  initial begin
    int o, spd, dem;
    model_reset();
    hold_reset(3);

    // Soft-start ramp to High, fan only.
    drive(1, 3, 0, 12);

    // First compressor start waits the full off-time.
    hold_reset(2);
    drive(1, 1, 1, OFF_NEED + 6);

    // Demand blip in RUN restarts the off-time wait.
    drive(1, 1, 0, 1);
    drive(1, 1, 1, OFF_NEED + 6);

    // Ramp to High in RUN, power off, full purge, then a purge interrupted at cycle 3.
    drive(1, 3, 1, 12);
    drive(0, 3, 1, PURGE_TICKS + 3);
    drive(1, 3, 1, OFF_NEED + 12);
    drive(0, 3, 1, 3);
    drive(1, 3, 1, 12);

    // Speed step-down in RUN keeps the compressor on.
    drive(1, 3, 1, OFF_NEED + 12);
    drive(1, 1, 1, 12);
    drive(1, 0, 1, 4);

    // Asynchronous reset in RUN, then a restart that waits the full off-time.
    drive(1, 3, 1, 4);
    async_reset();
    hold_reset(2);
    drive(1, 1, 1, OFF_NEED + 6);

    // Randomized operation with occasional async resets.
    o = 1; spd = 1; dem = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) o = 1 - o;
      if ($urandom_range(0, 14) == 0) dem = 1 - dem;
      if ($urandom_range(0, 19) == 0) spd = int'($urandom_range(0, 3));
      if ($urandom_range(0, 699) == 0) begin
        async_reset();
        hold_reset(1);
      end
      drive(o, spd, dem, 1);
    end

    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
